// File: rtl/io_tx_buffer.sv
// CPU-to-UART transmit buffer: captures I/O-window byte writes, queues them,
// and drains them over a valid/ready link; handles the program-stop terminator.
module io_tx_buffer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_mem_a,
    input  logic [7:0]  cpu_mem_dout,
    input  logic        cpu_mem_wr,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic        overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;   // pointer width incl. wrap bit
    localparam int OW    = DEPTH_LOG2 + 2;   // occupancy width (FIFO + output reg)

    typedef struct packed {
        logic       term;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STOP_PEND,
        ST_STOPPED
    } stop_state_t;

    stop_state_t st, st_nxt;

    entry_t          mem [DEPTH];
    entry_t          head, push_entry;
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic [OW-1:0]   occ_nxt;
    logic            tx_term;
    logic            io_wr, byte_wr, stop_wr;
    logic            fifo_full, fifo_empty, push, pop, hs;
    logic            tx_valid_nxt, full_nxt;
    logic            stop_pending;
    logic            unused_addr;

    assign unused_addr = ^{cpu_mem_a[31:18], cpu_mem_a[15:3]};

    // Writes are shut off once a stop has been requested, until reset.
    assign stop_pending = (st == ST_STOP_PEND);
    assign io_wr   = rdy_in && cpu_mem_wr && (cpu_mem_a[17:16] == 2'b11) && (st == ST_RUN);
    assign byte_wr = io_wr && (cpu_mem_a[2:0] == 3'd0) && (cpu_mem_dout != 8'h00);
    assign stop_wr = io_wr && (cpu_mem_a[2:0] == 3'd4);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

    assign hs   = tx_valid && tx_ready;
    assign pop  = !fifo_empty && (!tx_valid || tx_ready);
    // Byte writes and the terminator are never requested in the same cycle.
    assign push = !fifo_full && (byte_wr || stop_pending);
    assign head = mem[rd_ptr[PW-2:0]];

    always_comb begin
        push_entry = entry_t'{term: 1'b0, data: cpu_mem_dout};
        if (stop_pending)
            push_entry = entry_t'{term: 1'b1, data: 8'h00};
    end

    always_comb begin
        wr_ptr_nxt   = wr_ptr + PW'(push);
        rd_ptr_nxt   = rd_ptr + PW'(pop);
        count_nxt    = wr_ptr_nxt - rd_ptr_nxt;
        tx_valid_nxt = pop || (tx_valid && !tx_ready);
        occ_nxt      = OW'(count_nxt) + OW'(tx_valid_nxt);
        // Margin leaves room for writes already in flight upstream.
        full_nxt     = (OW'(DEPTH + 1) - occ_nxt) <= OW'(FULL_MARGIN);
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_RUN:       if (stop_wr)    st_nxt = ST_STOP_PEND;
            ST_STOP_PEND: if (!fifo_full) st_nxt = ST_STOPPED;
            ST_STOPPED:   st_nxt = ST_STOPPED;
            default:      st_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr[PW-2:0]] <= push_entry;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            st             <= ST_RUN;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            tx_valid       <= 1'b0;
            tx_data        <= 8'h00;
            tx_term        <= 1'b0;
            io_buffer_full <= 1'b0;
            prog_stop      <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            st             <= st_nxt;
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            tx_valid       <= tx_valid_nxt;
            io_buffer_full <= full_nxt;
            if (pop) begin
                tx_data <= head.data;
                tx_term <= head.term;
            end
            if (byte_wr && fifo_full)
                overflow <= 1'b1;
            if (hs && tx_term)
                prog_stop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_tx_buffer.sv
// Randomized scoreboard bench for io_tx_buffer: driver predicts the byte stream,
// a negedge monitor pops and compares every handshake.
module tb_io_tx_buffer;

    localparam int CAP    = 17;   // FIFO entries + output register
    localparam int MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_mem_a;
    logic [7:0]  cpu_mem_dout;
    logic        cpu_mem_wr;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        prog_stop;
    logic        overflow;

    always #5 clk_in = ~clk_in;

    io_tx_buffer #(.DEPTH_LOG2(4), .FULL_MARGIN(MARGIN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_mem_a(cpu_mem_a), .cpu_mem_dout(cpu_mem_dout), .cpu_mem_wr(cpu_mem_wr),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .prog_stop(prog_stop), .overflow(overflow)
    );

    typedef struct {
        logic [7:0] data;
        logic       term;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   acc   = 0;    // bytes accepted since reset (driver)
    int   hs    = 0;    // handshakes since reset (monitor)
    bit   m_stopped = 0;
    bit   m_ov      = 0;
    bit   ps_exp    = 0;

    logic [31:0] addrs [8] = '{32'h0003_0000, 32'h0003_0008, 32'h0003_0001, 32'h0003_0006,
                               32'h0002_0000, 32'h0001_0000, 32'hFFF3_0000, 32'h0000_0000};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One CPU-side cycle: predict the effect, let the edge happen, check sticky/back-pressure.
    task automatic step(input logic rdy, input logic wr, input logic [31:0] a,
                        input logic [7:0] d, input logic txr);
        rdy_in = rdy; cpu_mem_wr = wr; cpu_mem_a = a; cpu_mem_dout = d; tx_ready = txr;
        if (rdy && wr && a[17:16] == 2'b11 && !m_stopped) begin
            if (a[2:0] == 3'd0 && d != 8'h00) begin
                if (acc - hs >= CAP) m_ov = 1;
                else begin
                    sb.push_back('{data: d, term: 1'b0});
                    acc++;
                end
            end else if (a[2:0] == 3'd4) begin
                sb.push_back('{data: 8'h00, term: 1'b1});
                m_stopped = 1;
            end
        end
        @(posedge clk_in); #1;
        check("overflow", overflow, m_ov);
        if (!m_stopped)
            check("io_buffer_full", io_buffer_full, (CAP - (acc - hs)) <= MARGIN);
    endtask

    task automatic idle(input logic txr);
        step(1'b1, 1'b0, 32'h0, 8'h00, txr);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || tx_valid) && n < max) begin
            idle(1'b1);
            n++;
        end
        check("drain_outstanding", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_io_buffer_full"}, io_buffer_full, 0);
        check({tag, "_prog_stop"}, prog_stop, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    // Async reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset();
        cpu_mem_wr = 1'b0;
        @(posedge clk_in); #3;
        rst_in = 1'b1;
        sb.delete(); acc = 0; m_stopped = 0; m_ov = 0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    task automatic test_single(input logic [7:0] b);
        step(1'b1, 1'b1, 32'h0003_0000, b, 1'b1);
        check("lat_t_valid", tx_valid, 0);
        idle(1'b1);
        check("lat_t1_valid", tx_valid, 1);
        check("lat_t1_data", tx_data, b);
        check("lat_full", io_buffer_full, 0);
        idle(1'b1);
        check("pulse_end_valid", tx_valid, 0);
    endtask

    // Monitor: compares each handshake against the scoreboard and checks stall stability.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        exp_t       e;
        prev_stall = 0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                hs = 0; ps_exp = 0; prev_stall = 0;
            end else begin
                check("prog_stop", prog_stop, ps_exp);
                if (prev_stall) begin
                    check("stall_valid", tx_valid, 1);
                    check("stall_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    hs++;
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_data, $time);
                    end else begin
                        e = sb.pop_front();
                        check("tx_data", tx_data, e.data);
                        if (e.term) ps_exp = 1;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic       r, w, txr;
        logic [7:0] d;
        rst_in = 1'b1; rdy_in = 1'b0; cpu_mem_wr = 1'b0; cpu_mem_a = 32'h0;
        cpu_mem_dout = 8'h00; tx_ready = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_outputs("reset");
        rst_in = 1'b0;

        // 1: single byte latency and pulse
        test_single(8'h41);

        // 2: fill with sink stalled, overflow, then gapless drain
        for (int i = 1; i <= 18; i++)
            step(1'b1, 1'b1, 32'h0003_0000, 8'(i), 1'b0);
        check("fill_full", io_buffer_full, 1);
        check("fill_overflow", overflow, 1);
        for (int k = 1; k <= 16; k++) begin
            idle(1'b1);
            check("gapless_valid", tx_valid, 1);
        end
        idle(1'b1);
        check("drain_end_valid", tx_valid, 0);
        drain(40);

        // 3: ignored writes (zero data, non-I/O address, rdy_in low, other offset)
        step(1'b1, 1'b1, 32'h0003_0000, 8'h00, 1'b1);
        step(1'b1, 1'b1, 32'h0002_0000, 8'h55, 1'b1);
        step(1'b0, 1'b1, 32'h0003_0000, 8'h66, 1'b1);
        step(1'b1, 1'b1, 32'h0003_0002, 8'h77, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check("ignored_no_valid", tx_valid, 0);
        end

        // 5: sink toggling every cycle while streaming
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 32'h0003_0000, 8'hA0 + 8'(i), 1'(i % 2));
        for (int i = 0; i < 8; i++)
            idle(1'(i % 2));
        drain(40);

        // random traffic: slow sink first (drops), then fast sink
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 7) != 0);
            w   = ($urandom_range(0, 9) < 6);
            d   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            txr = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            step(r, w, addrs[$urandom_range(0, 7)], d, txr);
        end
        drain(200);

        // 4: program stop terminator
        step(1'b1, 1'b1, 32'h0003_0000, 8'h48, 1'b1);
        step(1'b1, 1'b1, 32'h0003_0000, 8'h49, 1'b1);
        step(1'b1, 1'b1, 32'h0003_0004, 8'h07, 1'b1);
        drain(40);
        check("stop_prog_stop", prog_stop, 1);
        step(1'b1, 1'b1, 32'h0003_0000, 8'h5A, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            check("after_stop_no_valid", tx_valid, 0);
        end

        // 6: async reset mid-stream with buffer nearly full
        do_reset();
        for (int i = 1; i <= 16; i++)
            step(1'b1, 1'b1, 32'h0003_0000, 8'h60 + 8'(i), 1'b0);
        check("pre_reset_valid", tx_valid, 1);
        check("pre_reset_full", io_buffer_full, 1);
        do_reset();
        test_single(8'h42);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
